// File: rtl/uart_tx_port_if.sv
// rtl/uart_tx_port_if.sv - processor-side bus bundle for the serial transmit port
//
// Signals:
//   WriteEnable  store strobe to the TX port address (processor -> port)
//   WriteData    byte to enqueue, store data bits [7:0] (processor -> port)
//   Tx           registered serial line, idles high (port -> line)
//   Busy         a frame is in progress
//   Full/Empty   FIFO occupancy flags
//   Count        FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//   Overflow     sticky, a write was dropped because the FIFO was full
// Modports: master = processor side, slave = the transmit port.
interface uart_tx_port_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          WriteEnable;
    logic [7:0]    WriteData;
    logic          Tx;
    logic          Busy;
    logic          Full;
    logic          Empty;
    logic [CW-1:0] Count;
    logic          Overflow;

    modport master (
        output WriteEnable, WriteData,
        input  Tx, Busy, Full, Empty, Count, Overflow
    );

    modport slave (
        input  WriteEnable, WriteData,
        output Tx, Busy, Full, Empty, Count, Overflow
    );
endinterface

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - byte FIFO plus 8N1 serializer for the processor output port
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; flushes FIFO, aborts any frame, Tx high
//   port   uart_tx_port_if.slave (WriteEnable/WriteData in; Tx, Busy, Full,
//          Empty, Count, Overflow out)
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_port_if.slave   port
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic full, empty, push, pop, baud_last;
    logic [7:0] head;

    assign full      = (count_q == COUNT_FULL);
    assign empty     = (count_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        // Full is taken from the registered count, so a write that meets a
        // full FIFO is dropped even if this same cycle pops an entry.
        push       = port.WriteEnable && !full;
        overflow_d = overflow_q | (port.WriteEnable & full);

        // tx_d is the line level for the state being entered, so Tx changes
        // on the same edge as the state/bit it belongs to.
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = 1'b0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = shift_q[0];
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = head;
                        bit_idx_d = '0;
                        state_d   = START;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d   = (state_d != IDLE);
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= port.WriteData;
            end
        end
    end

    assign port.Tx       = tx_q;
    assign port.Busy     = busy_q;
    assign port.Full     = full;
    assign port.Empty    = empty;
    assign port.Count    = count_q;
    assign port.Overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed self-checking bench for uart_tx_port
module tb_uart_tx_port;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_port_if #(.FIFO_DEPTH(4)) bus ();

    uart_tx_port #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .port (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Checks frame samples first..last (sample 0 = first start-bit cycle),
    // advancing one negedge per sample.
    task automatic check_frame(input logic [7:0] b, input int first, input int last, input string name);
        int   bad;
        logic exp;
        bad = 0;
        for (int i = first; i <= last; i++) begin
            if (i < 4)       exp = 1'b0;
            else if (i >= 36) exp = 1'b1;
            else             exp = b[(i - 4) / 4];
            if (bus.Tx !== exp) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s frame %02h: %0d wrong bit samples, required 0", name, b, bad);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.WriteEnable = 1'b1;
        bus.WriteData   = b;
        @(negedge clk);
        bus.WriteEnable = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (bus.Tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.Tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start timeout: Tx %b, required 0", name, bus.Tx);
        end
    endtask

    task automatic test_reset();
        chk("rst_tx",       {7'd0, bus.Tx},       8'd1);
        chk("rst_busy",     {7'd0, bus.Busy},     8'd0);
        chk("rst_empty",    {7'd0, bus.Empty},    8'd1);
        chk("rst_full",     {7'd0, bus.Full},     8'd0);
        chk("rst_count",    {5'd0, bus.Count},    8'd0);
        chk("rst_overflow", {7'd0, bus.Overflow}, 8'd0);
    endtask

    task automatic test_single_byte();
        write_byte(8'hA5);
        chk("single_count_latency", {5'd0, bus.Count}, 8'd1);
        chk("single_empty_latency", {7'd0, bus.Empty}, 8'd0);
        chk("single_tx_before_pop", {7'd0, bus.Tx},    8'd1);
        @(negedge clk);
        chk("single_busy_rise", {7'd0, bus.Busy}, 8'd1);
        check_frame(8'hA5, 0, 39, "single");
        chk("single_busy_fall", {7'd0, bus.Busy},  8'd0);
        chk("single_tx_idle",   {7'd0, bus.Tx},    8'd1);
        chk("single_empty_end", {7'd0, bus.Empty}, 8'd1);
    endtask

    task automatic test_burst();
        bus.WriteEnable = 1'b1;
        bus.WriteData   = 8'h01;
        @(negedge clk);
        chk("burst_count_1", {5'd0, bus.Count}, 8'd1);
        bus.WriteData = 8'h02;
        @(negedge clk);
        chk("burst_start_0", {7'd0, bus.Tx},    8'd0);
        chk("burst_count_2", {5'd0, bus.Count}, 8'd1);
        bus.WriteData = 8'h03;
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        chk("burst_count_peak", {5'd0, bus.Count}, 8'd2);
        check_frame(8'h01, 1, 39, "burst_f1");
        chk("burst_count_after_pop2", {5'd0, bus.Count}, 8'd1);
        check_frame(8'h02, 0, 39, "burst_f2");
        chk("burst_empty_after_pop3", {7'd0, bus.Empty}, 8'd1);
        check_frame(8'h03, 0, 39, "burst_f3");
        chk("burst_busy_end", {7'd0, bus.Busy}, 8'd0);
    endtask

    task automatic test_overflow();
        int glitches;
        bus.WriteEnable = 1'b1;
        bus.WriteData   = 8'hEE;
        @(negedge clk);
        bus.WriteData = 8'h10;          // pushed on the same edge EE pops
        @(negedge clk);
        bus.WriteData = 8'h11;
        @(negedge clk);
        bus.WriteData = 8'h12;
        @(negedge clk);
        chk("ovf_overflow_clear", {7'd0, bus.Overflow}, 8'd0);
        bus.WriteData = 8'h13;
        @(negedge clk);
        chk("ovf_count_4", {5'd0, bus.Count}, 8'd4);
        chk("ovf_full",    {7'd0, bus.Full},  8'd1);
        bus.WriteData = 8'h14;          // presented while full: dropped
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        chk("ovf_overflow_set", {7'd0, bus.Overflow}, 8'd1);
        chk("ovf_count_held",   {5'd0, bus.Count},    8'd4);
        check_frame(8'hEE, 4, 39, "ovf_fEE");
        check_frame(8'h10, 0, 39, "ovf_f10");
        check_frame(8'h11, 0, 39, "ovf_f11");
        check_frame(8'h12, 0, 39, "ovf_f12");
        check_frame(8'h13, 0, 39, "ovf_f13");
        glitches = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0) glitches++;
            @(negedge clk);
        end
        chk("ovf_dropped_not_sent", glitches[7:0], 8'd0);
        chk("ovf_sticky",           {7'd0, bus.Overflow}, 8'd1);
    endtask

    task automatic test_push_pop_same_cycle();
        bus.WriteEnable = 1'b1;
        bus.WriteData   = 8'hA1;
        @(negedge clk);
        bus.WriteData = 8'hB2;
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        chk("pp_count_before", {5'd0, bus.Count}, 8'd1);
        check_frame(8'hA1, 0, 38, "pp_fA1");
        chk("pp_last_stop_high", {7'd0, bus.Tx}, 8'd1);
        bus.WriteEnable = 1'b1;         // lands on the final stop-bit edge
        bus.WriteData   = 8'hC3;
        @(negedge clk);
        chk("pp_count_same",  {5'd0, bus.Count}, 8'd1);
        chk("pp_no_gap",      {7'd0, bus.Tx},    8'd0);
        bus.WriteData = 8'hD4;          // written to the wrapped pointer slot
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        chk("pp_count_wrap", {5'd0, bus.Count}, 8'd2);
        check_frame(8'hB2, 1, 39, "pp_fB2");
        check_frame(8'hC3, 0, 39, "pp_fC3");
        check_frame(8'hD4, 0, 39, "pp_fD4");
        chk("pp_empty_end", {7'd0, bus.Empty}, 8'd1);
    endtask

    task automatic test_reset_mid_frame();
        int glitches;
        bus.WriteEnable = 1'b1;
        bus.WriteData   = 8'h3C;        // zeros in bits 0..1 so Tx is low in bit 3? no: bit3 = 1
        bus.WriteData   = 8'h00;
        @(negedge clk);
        bus.WriteData = 8'h4D;
        @(negedge clk);
        bus.WriteData = 8'h5E;
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        chk("rmf_count_queued", {5'd0, bus.Count}, 8'd2);
        repeat (16) @(negedge clk);     // sample 17: inside data bit 3
        chk("rmf_tx_low_before", {7'd0, bus.Tx}, 8'd0);
        reset = 1'b1;
        #1;
        chk("rmf_tx",       {7'd0, bus.Tx},       8'd1);
        chk("rmf_count",    {5'd0, bus.Count},    8'd0);
        chk("rmf_busy",     {7'd0, bus.Busy},     8'd0);
        chk("rmf_empty",    {7'd0, bus.Empty},    8'd1);
        chk("rmf_overflow", {7'd0, bus.Overflow}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        glitches = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0) glitches++;
            @(negedge clk);
        end
        chk("rmf_no_resume", glitches[7:0], 8'd0);
        write_byte(8'h69);
        wait_start("rmf_new");
        check_frame(8'h69, 0, 39, "rmf_f69");
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        bus.WriteEnable = 1'b0;
        bus.WriteData   = 8'h00;
        #2 reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_single_byte();
        test_burst();
        test_overflow();
        test_push_pop_same_cycle();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
